// File: rtl/stopwatch_display_pkg.sv
// Shared types and constants for the stopwatch MM:SS seven-segment display.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_COMMIT
  } conv_state_e;

  typedef logic [1:0] digit_idx_t;

  localparam int TIME_W   = 6;
  localparam int BLINK_MS = 500;

  typedef struct packed {
    logic [3:0] min_t;
    logic [3:0] min_o;
    logic [3:0] sec_t;
    logic [3:0] sec_o;
    logic       blink;
  } disp_frame_t;

  // Segment order {g,f,e,d,c,b,a}; non-decimal nibbles render dark.
  function automatic logic [6:0] seg7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/stopwatch_display_bcd_convert.sv
// Sequential double-dabble: converts a BIN_W-bit value (< 100) into two BCD
// nibbles, one bit per cycle, after a one-cycle load on start.
module bcd_convert #(
  parameter int BIN_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic [3:0]       bcd_tens,
  output logic [3:0]       bcd_ones,
  output logic             done
);
  localparam int IW = $clog2(BIN_W + 1);
  localparam int SR_W = BIN_W + 8;

  logic [SR_W-1:0] sr_q, sr_d, adj;
  logic [IW-1:0]   iter_q, iter_d;
  logic            busy_q, busy_d;

  always_comb begin
    adj = sr_q;
    if (adj[BIN_W+3 -: 4] >= 4'd5) adj[BIN_W+3 -: 4] = adj[BIN_W+3 -: 4] + 4'd3;
    if (adj[BIN_W+7 -: 4] >= 4'd5) adj[BIN_W+7 -: 4] = adj[BIN_W+7 -: 4] + 4'd3;

    sr_d   = sr_q;
    iter_d = iter_q;
    busy_d = busy_q;
    if (start) begin
      sr_d   = {8'd0, bin};
      iter_d = IW'(BIN_W - 1);
      busy_d = 1'b1;
    end else if (busy_q) begin
      sr_d = adj << 1;
      if (iter_q == '0) busy_d = 1'b0;
      else              iter_d = iter_q - IW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q   <= '0;
      iter_q <= '0;
      busy_q <= 1'b0;
    end else begin
      sr_q   <= sr_d;
      iter_q <= iter_d;
      busy_q <= busy_d;
    end
  end

  // done marks the cycle whose shift produces the final digits.
  assign done     = busy_q && (iter_q == '0);
  assign bcd_tens = sr_q[BIN_W+7 -: 4];
  assign bcd_ones = sr_q[BIN_W+3 -: 4];

endmodule

// File: rtl/stopwatch_display.sv
// MM:SS multiplexed seven-segment driver fed by a once-per-frame snapshot of
// the stopwatch counter; new digits take effect only at frame boundaries.
module stopwatch_display
  import stopwatch_pkg::*;
#(
  parameter int SCAN_DIV   = 10000,
  parameter int LEAD_BLANK = 1
) (
  input  logic       clk_high_speed,
  input  logic       rst_n,
  input  logic [9:0] time_ms,
  input  logic [5:0] time_sec,
  input  logic [5:0] time_min,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] digit_n
);
  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

  if (SCAN_DIV < 9) begin : g_scan_div_check
    $error("stopwatch_display: SCAN_DIV must be at least 9");
  end

  logic [CNT_W-1:0] cnt_q, cnt_d;
  digit_idx_t       idx_q, idx_d;
  conv_state_e      state_q, state_d;
  logic             blink_snap_q, blink_snap_d;
  disp_frame_t      pend_q, pend_d;
  disp_frame_t      disp_q, disp_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;
  logic [3:0]       digit_n_q, digit_n_d;

  logic             period_end, frame_end;
  logic             conv_start, min_done, sec_done;
  logic [3:0]       min_tens, min_ones, sec_tens, sec_ones;
  logic [3:0]       nib;

  bcd_convert #(.BIN_W(TIME_W)) u_min_bcd (
    .clk      (clk_high_speed),
    .rst_n    (rst_n),
    .start    (conv_start),
    .bin      (time_min),
    .bcd_tens (min_tens),
    .bcd_ones (min_ones),
    .done     (min_done)
  );

  bcd_convert #(.BIN_W(TIME_W)) u_sec_bcd (
    .clk      (clk_high_speed),
    .rst_n    (rst_n),
    .start    (conv_start),
    .bin      (time_sec),
    .bcd_tens (sec_tens),
    .bcd_ones (sec_ones),
    .done     (sec_done)
  );

  always_comb begin
    period_end = (cnt_q == CNT_LAST);
    frame_end  = period_end && (idx_q == 2'd3);
    cnt_d      = period_end ? '0 : cnt_q + CNT_W'(1);
    idx_d      = period_end ? idx_q + 2'd1 : idx_q;
  end

  // Conversion sequencer: LOAD snapshots inputs, both converters shift in
  // lockstep, COMMIT publishes to the pending frame.
  always_comb begin
    state_d      = state_q;
    conv_start   = 1'b0;
    pend_d       = pend_q;
    blink_snap_d = blink_snap_q;
    case (state_q)
      ST_IDLE: begin
        if (idx_q == 2'd3 && cnt_q == '0) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        conv_start   = 1'b1;
        blink_snap_d = (time_ms < 10'(BLINK_MS));
        state_d      = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (min_done && sec_done) state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        pend_d.min_t = min_tens;
        pend_d.min_o = min_ones;
        pend_d.sec_t = sec_tens;
        pend_d.sec_o = sec_ones;
        pend_d.blink = blink_snap_q;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Take pend_d so a COMMIT landing on the frame's last cycle is not lost.
  assign disp_d = frame_end ? pend_d : disp_q;

  always_comb begin
    nib = disp_q.sec_o;
    case (idx_q)
      2'd0: nib = disp_q.sec_o;
      2'd1: nib = disp_q.sec_t;
      2'd2: nib = disp_q.min_o;
      2'd3: nib = disp_q.min_t;
      default: nib = disp_q.sec_o;
    endcase
    seg_d = seg7(nib);
    if (idx_q == 2'd3 && LEAD_BLANK != 0 && disp_q.min_t == 4'd0) seg_d = 7'h00;
    dp_d      = (idx_q == 2'd1) && disp_q.blink;
    digit_n_d = (cnt_q == '0) ? 4'b1111 : ~(4'b0001 << idx_q);
  end

  always_ff @(posedge clk_high_speed or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      state_q      <= ST_IDLE;
      blink_snap_q <= 1'b0;
      pend_q       <= '0;
      disp_q       <= '0;
      seg_q        <= 7'h00;
      dp_q         <= 1'b0;
      digit_n_q    <= 4'b1111;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      state_q      <= state_d;
      blink_snap_q <= blink_snap_d;
      pend_q       <= pend_d;
      disp_q       <= disp_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      digit_n_q    <= digit_n_d;
    end
  end

  assign seg     = seg_q;
  assign dp      = dp_q;
  assign digit_n = digit_n_q;

endmodule

// File: tb/tb_stopwatch_display.sv
// Scoreboard bench for stopwatch_display: stimulus queues the expected frame
// contents, a monitor checks every digit period against them.
module tb_stopwatch_display;

  localparam int S = 16;
  localparam int FRAME = 4 * S;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [9:0] time_ms = '0;
  logic [5:0] time_sec = '0;
  logic [5:0] time_min = '0;
  logic [6:0] seg_a, seg_b;
  logic       dp_a, dp_b;
  logic [3:0] dn_a, dn_b;

  always #5 clk = ~clk;

  stopwatch_display #(.SCAN_DIV(S), .LEAD_BLANK(1)) dut (
    .clk_high_speed (clk),
    .rst_n          (rst_n),
    .time_ms        (time_ms),
    .time_sec       (time_sec),
    .time_min       (time_min),
    .seg            (seg_a),
    .dp             (dp_a),
    .digit_n        (dn_a)
  );

  stopwatch_display #(.SCAN_DIV(S), .LEAD_BLANK(0)) dut_nb (
    .clk_high_speed (clk),
    .rst_n          (rst_n),
    .time_ms        (time_ms),
    .time_sec       (time_sec),
    .time_min       (time_min),
    .seg            (seg_b),
    .dp             (dp_b),
    .digit_n        (dn_b)
  );

  typedef struct {
    int         fr;
    int         id;
    logic [6:0] seg;
    logic [6:0] seg_nb;
    logic       dp;
  } exp_t;

  exp_t sb_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;

  // Posedges since the last reset release; outputs at a negedge show cycle cyc-1.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %02h expected %02h (cyc %0d)", nm, got, exp, cyc);
    end
  endtask

  task automatic push_frame(input int fr, input logic [6:0] s3, input logic [6:0] s3nb,
                            input logic [6:0] s2, input logic [6:0] s1,
                            input logic [6:0] s0, input logic dp1);
    exp_t e;
    e.fr = fr;
    e.id = 0; e.seg = s0; e.seg_nb = s0;   e.dp = 1'b0; sb_q.push_back(e);
    e.id = 1; e.seg = s1; e.seg_nb = s1;   e.dp = dp1;  sb_q.push_back(e);
    e.id = 2; e.seg = s2; e.seg_nb = s2;   e.dp = 1'b0; sb_q.push_back(e);
    e.id = 3; e.seg = s3; e.seg_nb = s3nb; e.dp = 1'b0; sb_q.push_back(e);
  endtask

  task automatic wait_cyc(input int n);
    for (int i = 0; i < 1000 && cyc != n; i++) @(negedge clk);
    if (cyc != n) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_cyc: reached %0d required %0d", cyc, n);
    end
  endtask

  // Monitor
  exp_t       cur;
  exp_t       stale;
  bit         cur_v = 1'b0;
  int         m_k, m_c, m_id, m_fr;
  logic [3:0] exp_dn;

  always @(negedge clk) begin
    if (rst_n && cyc >= 1) begin
      m_k  = cyc - 1;
      m_c  = m_k % S;
      m_id = (m_k / S) % 4;
      m_fr = m_k / FRAME;
      if (m_c == 0) begin
        cur_v = 1'b0;
        while (sb_q.size() > 0 && (sb_q[0].fr * 4 + sb_q[0].id) < (m_fr * 4 + m_id)) begin
          stale = sb_q.pop_front();
          vectors++;
          miscompares++;
          $display("FAIL missed f%0d d%0d: got no check, required one", stale.fr, stale.id);
        end
        if (sb_q.size() > 0 && sb_q[0].fr == m_fr && sb_q[0].id == m_id) begin
          cur   = sb_q.pop_front();
          cur_v = 1'b1;
          chk($sformatf("f%0d d%0d blank digit_n", m_fr, m_id), 8'(dn_a), 8'h0F);
          chk($sformatf("f%0d d%0d blank digit_n_nb", m_fr, m_id), 8'(dn_b), 8'h0F);
        end
      end else if (cur_v) begin
        exp_dn       = 4'b1111;
        exp_dn[m_id] = 1'b0;
        chk($sformatf("f%0d d%0d digit_n", m_fr, m_id), 8'(dn_a), 8'(exp_dn));
        chk($sformatf("f%0d d%0d seg", m_fr, m_id), 8'(seg_a), 8'(cur.seg));
        chk($sformatf("f%0d d%0d dp", m_fr, m_id), 8'(dp_a), 8'(cur.dp));
        chk($sformatf("f%0d d%0d seg_nb", m_fr, m_id), 8'(seg_b), 8'(cur.seg_nb));
      end
    end
  end

  initial begin
    time_min = 6'd12; time_sec = 6'd34; time_ms = 10'd100;
    #1 rst_n = 1'b0;
    #1;
    chk("reset seg", 8'(seg_a), 8'h00);
    chk("reset dp", 8'(dp_a), 8'h00);
    chk("reset digit_n", 8'(dn_a), 8'h0F);
    chk("reset digit_n_nb", 8'(dn_b), 8'h0F);

    // Frame 0: reset contents; frame 1: 12:34, ms 100.
    push_frame(0, 7'h00, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 1'b0);
    push_frame(1, 7'h06, 7'h06, 7'h5B, 7'h4F, 7'h66, 1'b1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // 05:07, ms 499: leading blank on the LEAD_BLANK=1 unit only.
    wait_cyc(FRAME + 2);
    time_min = 6'd5; time_sec = 6'd7; time_ms = 10'd499;
    push_frame(2, 7'h00, 7'h3F, 7'h6D, 7'h3F, 7'h07, 1'b1);

    // 63:63, ms 500: out-of-range shown literally, blink off.
    wait_cyc(2 * FRAME + 2);
    time_min = 6'd63; time_sec = 6'd63; time_ms = 10'd500;
    push_frame(3, 7'h7D, 7'h7D, 7'h4F, 7'h7D, 7'h4F, 1'b0);

    // 00:59 then, one cycle after frame 4's LOAD, 01:00.
    wait_cyc(3 * FRAME + 2);
    time_min = 6'd0; time_sec = 6'd59; time_ms = 10'd0;
    push_frame(4, 7'h00, 7'h3F, 7'h3F, 7'h6D, 7'h6F, 1'b1);
    wait_cyc(4 * FRAME + 3 * S + 2);
    time_min = 6'd1; time_sec = 6'd0;
    push_frame(5, 7'h00, 7'h3F, 7'h3F, 7'h6D, 7'h6F, 1'b1);
    push_frame(6, 7'h00, 7'h3F, 7'h06, 7'h3F, 7'h3F, 1'b1);

    // Reset during the third SHIFT cycle of frame 7's conversion.
    wait_cyc(7 * FRAME + 2);
    time_min = 6'd42; time_sec = 6'd17; time_ms = 10'd750;
    wait_cyc(7 * FRAME + 3 * S + 4);
    chk("queue drained before reset", 8'(sb_q.size()), 8'h00);
    rst_n = 1'b0;
    #1;
    chk("mid reset seg", 8'(seg_a), 8'h00);
    chk("mid reset dp", 8'(dp_a), 8'h00);
    chk("mid reset digit_n", 8'(dn_a), 8'h0F);
    push_frame(0, 7'h00, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 1'b0);
    push_frame(1, 7'h66, 7'h66, 7'h5B, 7'h06, 7'h07, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    wait_cyc(2 * FRAME + 2);
    chk("queue drained at end", 8'(sb_q.size()), 8'h00);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
